// File: rtl/tcm_banked_dp_pkg.sv
// Shared types and elaboration-time helpers for the banked tightly-coupled memory.
package tcm_pkg;

    typedef enum logic {
        TCM_PORT_A = 1'b0,
        TCM_PORT_B = 1'b1
    } tcm_port_e;

    // Number of address bits needed to pick one bank out of depth/bank_depth.
    function automatic int bank_bits(int depth, int bank_depth);
        return $clog2(depth / bank_depth);
    endfunction

    // Bank index width; a single-bank memory still carries a 1-bit index tied to zero.
    function automatic int bi_width(int depth, int bank_depth);
        return (bank_bits(depth, bank_depth) == 0) ? 1 : bank_bits(depth, bank_depth);
    endfunction

    // Byte-offset bits dropped from a byte address to form a word address.
    function automatic int word_off_bits(int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/tcm_banked_dp_if.sv
// Request/response bundle for one TCM port (fetch or load/store).
interface tcm_banked_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/tcm_banked_dp_arb.sv
// Bank decode and round-robin arbitration between the fetch (A) and load/store (B) ports.
module tcm_bank_arb
    import tcm_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int OFF_BITS   = 2,
    parameter int BANK_NUM   = 8,
    parameter int BANK_BITS  = 3,
    parameter int BI_WIDTH   = 3,
    parameter int WA_BITS    = 10,
    parameter int INTERLEAVE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic [BI_WIDTH-1:0]   a_bi,
    output logic [BI_WIDTH-1:0]   b_bi,
    output logic [WA_BITS-1:0]    a_wa,
    output logic [WA_BITS-1:0]    b_wa,
    output logic [BANK_NUM-1:0]   bank_en,
    output logic [BANK_NUM-1:0]   bank_sel
);
    localparam int WW = ADDR_WIDTH - OFF_BITS;

    logic [WW-1:0] a_w;
    logic [WW-1:0] b_w;
    logic          conflict;
    tcm_port_e     rr_ptr;
    tcm_port_e     rr_next;

    assign a_w = a_addr[ADDR_WIDTH-1:OFF_BITS];
    assign b_w = b_addr[ADDR_WIDTH-1:OFF_BITS];

    if (BANK_BITS == 0) begin : g_single
        assign a_bi = '0;
        assign b_bi = '0;
        assign a_wa = a_w[WA_BITS-1:0];
        assign b_wa = b_w[WA_BITS-1:0];
    end else if (INTERLEAVE == 0) begin : g_contig
        assign a_bi = a_w[WW-1 -: BANK_BITS];
        assign b_bi = b_w[WW-1 -: BANK_BITS];
        assign a_wa = a_w[WA_BITS-1:0];
        assign b_wa = b_w[WA_BITS-1:0];
    end else begin : g_inter
        assign a_bi = a_w[BANK_BITS-1:0];
        assign b_bi = b_w[BANK_BITS-1:0];
        assign a_wa = a_w[WW-1:BANK_BITS];
        assign b_wa = b_w[WW-1:BANK_BITS];
    end

    assign conflict = a_req && b_req && (a_bi == b_bi);

    // Round-robin pointer register; favours A out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= TCM_PORT_A;
        end else begin
            rr_ptr <= rr_next;
        end
    end

    // Pointer moves only on a conflict, and then toward the port that just lost.
    always_comb begin
        rr_next = rr_ptr;
        if (conflict) begin
            rr_next = (rr_ptr == TCM_PORT_A) ? TCM_PORT_B : TCM_PORT_A;
        end
    end

    // Grants plus per-bank enable and port select (select=1 means port B owns the bank).
    always_comb begin
        a_gnt = !rst && a_req && (!conflict || (rr_ptr == TCM_PORT_A));
        b_gnt = !rst && b_req && (!conflict || (rr_ptr == TCM_PORT_B));
        for (int i = 0; i < BANK_NUM; i++) begin
            bank_en[i]  = (a_gnt && (a_bi == BI_WIDTH'(i))) || (b_gnt && (b_bi == BI_WIDTH'(i)));
            bank_sel[i] = b_gnt && (b_bi == BI_WIDTH'(i));
        end
    end
endmodule

// File: rtl/tcm_banked_dp_ram.sv
// Behavioural single-port RAM with byte enables and a synchronous read port.
module BW_SP_RAM #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int AW        = $clog2(DEPTH),
    localparam int BW        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [BW-1:0]         be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-masked write, or registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BW; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/tcm_banked_dp.sv
// Dual-port banked TCM: per-bank SRAMs, shared arbitration, per-port response pipelines.
module tcm_banked_dp
    import tcm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8192,
    parameter int BANK_DEPTH = 1024,
    parameter int INTERLEAVE = 0,
    parameter int RDATA_REG  = 0
) (
    input logic              clk_i,
    input logic              rst_i,
    tcm_banked_dp_if.slave   port_a,
    tcm_banked_dp_if.slave   port_b
);
    localparam int ADDR_WIDTH = $clog2(DEPTH * DATA_WIDTH / 8);
    localparam int BANK_NUM   = DEPTH / BANK_DEPTH;
    localparam int BANK_BITS  = bank_bits(DEPTH, BANK_DEPTH);
    localparam int BI_WIDTH   = bi_width(DEPTH, BANK_DEPTH);
    localparam int OFF_BITS   = word_off_bits(DATA_WIDTH);
    localparam int WA_BITS    = $clog2(BANK_DEPTH);
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    logic                  a_gnt;
    logic                  b_gnt;
    logic [BI_WIDTH-1:0]   a_bi;
    logic [BI_WIDTH-1:0]   b_bi;
    logic [WA_BITS-1:0]    a_wa;
    logic [WA_BITS-1:0]    b_wa;
    logic [BANK_NUM-1:0]   bank_en;
    logic [BANK_NUM-1:0]   bank_sel;
    logic [DATA_WIDTH-1:0] bank_rdata [BANK_NUM];

    logic [1:0]            acc;
    logic [1:0]            acc_we;
    logic [BI_WIDTH-1:0]   acc_bi [2];
    logic [1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data [2];

    tcm_bank_arb #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .OFF_BITS   (OFF_BITS),
        .BANK_NUM   (BANK_NUM),
        .BANK_BITS  (BANK_BITS),
        .BI_WIDTH   (BI_WIDTH),
        .WA_BITS    (WA_BITS),
        .INTERLEAVE (INTERLEAVE)
    ) u_arb (
        .clk      (clk_i),
        .rst      (rst_i),
        .a_req    (port_a.req),
        .a_addr   (port_a.addr),
        .b_req    (port_b.req),
        .b_addr   (port_b.addr),
        .a_gnt    (a_gnt),
        .b_gnt    (b_gnt),
        .a_bi     (a_bi),
        .b_bi     (b_bi),
        .a_wa     (a_wa),
        .b_wa     (b_wa),
        .bank_en  (bank_en),
        .bank_sel (bank_sel)
    );

    assign port_a.gnt = a_gnt;
    assign port_b.gnt = b_gnt;

    for (genvar i = 0; i < BANK_NUM; i++) begin : g_bank
        logic                  ram_we;
        logic [BE_WIDTH-1:0]   ram_be;
        logic [WA_BITS-1:0]    ram_addr;
        logic [DATA_WIDTH-1:0] ram_wdata;

        // Steer the owning port's command onto this bank.
        always_comb begin
            if (bank_sel[i]) begin
                ram_we    = port_b.we;
                ram_be    = port_b.be;
                ram_addr  = b_wa;
                ram_wdata = port_b.wdata;
            end else begin
                ram_we    = port_a.we;
                ram_be    = port_a.be;
                ram_addr  = a_wa;
                ram_wdata = port_a.wdata;
            end
        end

`ifdef ASIC
        logic [DATA_WIDTH-1:0] bit_mask;
        for (genvar k = 0; k < BE_WIDTH; k++) begin : g_mask
            assign bit_mask[8*k +: 8] = {8{ram_be[k]}};
        end
        tcm_sram_macro u_ram (
            .CLK  (clk_i),
            .CEN  (~bank_en[i]),
            .WEN  (~ram_we),
            .BWEN (~bit_mask),
            .A    (ram_addr),
            .D    (ram_wdata),
            .Q    (bank_rdata[i])
        );
`else
        BW_SP_RAM #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BANK_DEPTH)
        ) u_ram (
            .clk   (clk_i),
            .en    (bank_en[i]),
            .we    (ram_we),
            .be    (ram_be),
            .addr  (ram_addr),
            .wdata (ram_wdata),
            .rdata (bank_rdata[i])
        );
`endif
    end

    assign acc       = {b_gnt, a_gnt};
    assign acc_we    = {port_b.we, port_a.we};
    assign acc_bi[0] = a_bi;
    assign acc_bi[1] = b_bi;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  v1;
        logic [BI_WIDTH-1:0]   rd_sel;
        logic [DATA_WIDTH-1:0] mux_data;

        // First response stage; the bank select only follows accepted reads.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                v1     <= 1'b0;
                rd_sel <= '0;
            end else begin
                v1 <= acc[p];
                if (acc[p] && !acc_we[p]) begin
                    rd_sel <= acc_bi[p];
                end
            end
        end

        // Pick the output of the bank that served this port's last read.
        always_comb begin
            mux_data = '0;
            for (int b = 0; b < BANK_NUM; b++) begin
                if (rd_sel == BI_WIDTH'(b)) begin
                    mux_data = bank_rdata[b];
                end
            end
        end

        if (RDATA_REG != 0) begin : g_reg
            logic                  rvalid_q;
            logic [DATA_WIDTH-1:0] rdata_q;

            // Optional output register stage for timing closure.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= v1;
                    if (v1) begin
                        rdata_q <= mux_data;
                    end
                end
            end

            assign rsp_valid[p] = rvalid_q;
            assign rsp_data[p]  = rdata_q;
        end else begin : g_comb
            assign rsp_valid[p] = v1;
            assign rsp_data[p]  = mux_data;
        end
    end

    assign port_a.rvalid = rsp_valid[0];
    assign port_a.rdata  = rsp_data[0];
    assign port_b.rvalid = rsp_valid[1];
    assign port_b.rdata  = rsp_data[1];
endmodule

// File: tb/tb_tcm_banked_dp.sv
// Directed bench: default config via a vector table, plus interleaved and registered-output corners.
module tb_tcm_banked_dp;

    logic clk;
    logic rst;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic        a_req;
        logic        a_we;
        logic [14:0] a_addr;
        logic [3:0]  a_be;
        logic [31:0] a_wdata;
        logic        b_req;
        logic        b_we;
        logic [14:0] b_addr;
        logic [3:0]  b_be;
        logic [31:0] b_wdata;
        logic        exp_a_gnt;
        logic        exp_b_gnt;
        logic        chk_a;
        logic [31:0] exp_a_rdata;
        logic        chk_b;
        logic [31:0] exp_b_rdata;
    } vec_t;

    vec_t vecs[$];

    tcm_banked_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) if_a0();
    tcm_banked_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) if_b0();
    tcm_banked_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) if_a1();
    tcm_banked_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) if_b1();
    tcm_banked_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) if_a2();
    tcm_banked_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) if_b2();

    tcm_banked_dp dut0 (.clk_i(clk), .rst_i(rst), .port_a(if_a0.slave), .port_b(if_b0.slave));

    tcm_banked_dp #(.INTERLEAVE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .port_a(if_a1.slave), .port_b(if_b1.slave));

    tcm_banked_dp #(.DEPTH(1024), .BANK_DEPTH(1024), .RDATA_REG(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .port_a(if_a2.slave), .port_b(if_b2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n,
                                input logic ar, input logic aw, input logic [14:0] aa,
                                input logic [3:0] abe, input logic [31:0] ad,
                                input logic br, input logic bw, input logic [14:0] ba,
                                input logic [3:0] bbe, input logic [31:0] bd,
                                input logic eag, input logic ebg,
                                input logic ca, input logic [31:0] ea,
                                input logic cb, input logic [31:0] eb);
        vec_t v;
        v.name = n;
        v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_be = abe; v.a_wdata = ad;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_be = bbe; v.b_wdata = bd;
        v.exp_a_gnt = eag; v.exp_b_gnt = ebg;
        v.chk_a = ca; v.exp_a_rdata = ea;
        v.chk_b = cb; v.exp_b_rdata = eb;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        if_a0.req = v.a_req; if_a0.we = v.a_we; if_a0.addr = v.a_addr;
        if_a0.be = v.a_be;   if_a0.wdata = v.a_wdata;
        if_b0.req = v.b_req; if_b0.we = v.b_we; if_b0.addr = v.b_addr;
        if_b0.be = v.b_be;   if_b0.wdata = v.b_wdata;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        if_a0.req = 0; if_a0.we = 0; if_a0.addr = '0; if_a0.be = '0; if_a0.wdata = '0;
        if_b0.req = 0; if_b0.we = 0; if_b0.addr = '0; if_b0.be = '0; if_b0.wdata = '0;
        if_a1.req = 0; if_a1.we = 0; if_a1.addr = '0; if_a1.be = '0; if_a1.wdata = '0;
        if_b1.req = 0; if_b1.we = 0; if_b1.addr = '0; if_b1.be = '0; if_b1.wdata = '0;
        if_a2.req = 0; if_a2.we = 0; if_a2.addr = '0; if_a2.be = '0; if_a2.wdata = '0;
        if_b2.req = 0; if_b2.we = 0; if_b2.addr = '0; if_b2.be = '0; if_b2.wdata = '0;

        // Default config: bank = byte address bits [14:12]; 0x0000-0x0FFF bank 0, 0x2000 bank 2, 0x4000 bank 4.
        vecs.push_back(mk("par_rd_wr", 1,0,15'h0000,4'hF,32'h0, 1,1,15'h2000,4'hF,32'hDEADBEEF, 1,1, 0,32'h0, 0,32'h0));
        vecs.push_back(mk("b_raw",     0,0,15'h0000,4'hF,32'h0, 1,0,15'h2000,4'hF,32'h0,       0,1, 0,32'h0, 1,32'hDEADBEEF));
        vecs.push_back(mk("a_wr_ff",   1,1,15'h0010,4'hF,32'hFFFFFFFF, 0,0,15'h0,4'h0,32'h0,   1,0, 0,32'h0, 0,32'h0));
        vecs.push_back(mk("a_wr_be",   1,1,15'h0010,4'h5,32'h11223344, 0,0,15'h0,4'h0,32'h0,   1,0, 0,32'h0, 0,32'h0));
        vecs.push_back(mk("b_rd_be",   0,0,15'h0000,4'h0,32'h0, 1,0,15'h0010,4'hF,32'h0,       0,1, 0,32'h0, 1,32'hFF22FF44));
        vecs.push_back(mk("b_wr_20",   0,0,15'h0000,4'h0,32'h0, 1,1,15'h0020,4'hF,32'h0BADF00D, 0,1, 0,32'h0, 0,32'h0));
        vecs.push_back(mk("rr0",       1,0,15'h0010,4'hF,32'h0, 1,0,15'h0020,4'hF,32'h0,       1,0, 1,32'hFF22FF44, 0,32'h0));
        vecs.push_back(mk("rr1",       1,0,15'h0010,4'hF,32'h0, 1,0,15'h0020,4'hF,32'h0,       0,1, 0,32'h0, 1,32'h0BADF00D));
        vecs.push_back(mk("rr2",       1,0,15'h0010,4'hF,32'h0, 1,0,15'h0020,4'hF,32'h0,       1,0, 1,32'hFF22FF44, 0,32'h0));
        vecs.push_back(mk("rr3",       1,0,15'h0010,4'hF,32'h0, 1,0,15'h0020,4'hF,32'h0,       0,1, 0,32'h0, 1,32'h0BADF00D));
        vecs.push_back(mk("par_rd",    1,0,15'h2000,4'hF,32'h0, 1,0,15'h0010,4'hF,32'h0,       1,1, 1,32'hDEADBEEF, 1,32'hFF22FF44));
        vecs.push_back(mk("wr_and_rd", 1,1,15'h4004,4'hF,32'h13579BDF, 1,0,15'h0020,4'hF,32'h0, 1,1, 0,32'h0, 1,32'h0BADF00D));
        vecs.push_back(mk("cfl_a_win", 1,0,15'h4004,4'hF,32'h0, 1,1,15'h4008,4'hF,32'h2468ACE0, 1,0, 1,32'h13579BDF, 0,32'h0));
        vecs.push_back(mk("b_retry",   0,0,15'h0000,4'h0,32'h0, 1,1,15'h4008,4'hF,32'h2468ACE0, 0,1, 0,32'h0, 0,32'h0));
        vecs.push_back(mk("a_rd_4008", 1,0,15'h4008,4'hF,32'h0, 0,0,15'h0,4'h0,32'h0,          1,0, 1,32'h2468ACE0, 0,32'h0));
        vecs.push_back(mk("low_bits",  1,0,15'h4007,4'hF,32'h0, 0,0,15'h0,4'h0,32'h0,          1,0, 1,32'h13579BDF, 0,32'h0));

        // Reset state, with a request held high during reset.
        rst = 1'b1;
        if_a0.req = 1'b1;
        #12;
        check_output("rst_a_gnt", {31'b0, if_a0.gnt}, 32'h0);
        check_output("rst_a_rvalid", {31'b0, if_a0.rvalid}, 32'h0);
        check_output("rst_reg_rdata", if_a2.rdata, 32'h0);
        check_output("rst_reg_rvalid", {31'b0, if_a2.rvalid}, 32'h0);
        if_a0.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven vectors on the default config; one vector per cycle, back-to-back.
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output({vecs[i].name, "_a_gnt"}, {31'b0, if_a0.gnt}, {31'b0, vecs[i].exp_a_gnt});
            check_output({vecs[i].name, "_b_gnt"}, {31'b0, if_b0.gnt}, {31'b0, vecs[i].exp_b_gnt});
            @(posedge clk);
            #1;
            check_output({vecs[i].name, "_a_rvalid"}, {31'b0, if_a0.rvalid}, {31'b0, vecs[i].exp_a_gnt});
            check_output({vecs[i].name, "_b_rvalid"}, {31'b0, if_b0.rvalid}, {31'b0, vecs[i].exp_b_gnt});
            if (vecs[i].chk_a) check_output({vecs[i].name, "_a_rdata"}, if_a0.rdata, vecs[i].exp_a_rdata);
            if (vecs[i].chk_b) check_output({vecs[i].name, "_b_rdata"}, if_b0.rdata, vecs[i].exp_b_rdata);
        end
        apply_stimulus(mk("idle", 0,0,15'h0,4'h0,32'h0, 0,0,15'h0,4'h0,32'h0, 0,0, 0,32'h0, 0,32'h0));

        // Interleaved config: bank = word address bits [2:0].
        if_a1.req = 1; if_a1.addr = 15'h0000;
        if_b1.req = 1; if_b1.addr = 15'h0004;
        @(negedge clk);
        check_output("il_nocfl_a_gnt", {31'b0, if_a1.gnt}, 32'h1);
        check_output("il_nocfl_b_gnt", {31'b0, if_b1.gnt}, 32'h1);
        @(posedge clk); #1;
        check_output("il_nocfl_b_rvalid", {31'b0, if_b1.rvalid}, 32'h1);
        if_b1.addr = 15'h0020;
        @(negedge clk);
        check_output("il_cfl_a_gnt", {31'b0, if_a1.gnt}, 32'h1);
        check_output("il_cfl_b_gnt", {31'b0, if_b1.gnt}, 32'h0);
        @(posedge clk); #1;
        check_output("il_cfl_b_rvalid", {31'b0, if_b1.rvalid}, 32'h0);
        if_a1.req = 0;
        @(negedge clk);
        check_output("il_retry_b_gnt", {31'b0, if_b1.gnt}, 32'h1);
        @(posedge clk); #1;
        if_b1.we = 1; if_b1.addr = 15'h0024; if_b1.be = 4'hF; if_b1.wdata = 32'h5A5A1234;
        @(posedge clk); #1;
        if_b1.req = 0; if_b1.we = 0;
        if_a1.req = 1; if_a1.addr = 15'h0024;
        @(posedge clk); #1;
        check_output("il_rd_rvalid", {31'b0, if_a1.rvalid}, 32'h1);
        check_output("il_rd_rdata", if_a1.rdata, 32'h5A5A1234);
        if_a1.req = 0;

        // Registered output, single bank: preload three words.
        if_a2.req = 1; if_a2.we = 1; if_a2.be = 4'hF;
        for (int k = 0; k < 3; k++) begin
            if_a2.addr = 12'(4 * k);
            if_a2.wdata = {4{8'(k + 1)}};
            @(posedge clk); #1;
        end
        if_a2.req = 0; if_a2.we = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Back-to-back reads: responses land two cycles after each request.
        if_a2.req = 1; if_a2.addr = 12'h000;
        @(posedge clk); #1;
        check_output("reg_lat_c1_rvalid", {31'b0, if_a2.rvalid}, 32'h0);
        if_a2.addr = 12'h004;
        @(posedge clk); #1;
        check_output("reg_lat_c2_rvalid", {31'b0, if_a2.rvalid}, 32'h1);
        check_output("reg_lat_c2_rdata", if_a2.rdata, 32'h01010101);
        if_a2.addr = 12'h008;
        @(posedge clk); #1;
        check_output("reg_lat_c3_rvalid", {31'b0, if_a2.rvalid}, 32'h1);
        check_output("reg_lat_c3_rdata", if_a2.rdata, 32'h02020202);
        if_a2.req = 0;
        @(posedge clk); #1;
        check_output("reg_lat_c4_rvalid", {31'b0, if_a2.rvalid}, 32'h1);
        check_output("reg_lat_c4_rdata", if_a2.rdata, 32'h03030303);
        @(posedge clk); #1;
        check_output("reg_lat_c5_rvalid", {31'b0, if_a2.rvalid}, 32'h0);

        // Reset mid-burst with reads in flight: responses are dropped, not delivered later.
        if_a2.req = 1; if_a2.addr = 12'h004;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("midrst_pre_rvalid", {31'b0, if_a2.rvalid}, 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check_output("midrst_rvalid", {31'b0, if_a2.rvalid}, 32'h0);
        check_output("midrst_rdata", if_a2.rdata, 32'h0);
        check_output("midrst_gnt", {31'b0, if_a2.gnt}, 32'h0);
        if_a2.req = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_output("postrst_rvalid", {31'b0, if_a2.rvalid}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
